ita_output_stage: RTL and testbench

//  Output stage fed by the controller/datapath: takes requantized N-lane result beats, zeroes padded lanes
//  per the requant lane mask, buffers final (last-inner-tile) beats in a FIFO, streams them out with valid/ready.

---
 rtl/ita_output_stage_pkg.sv | 22 ++
 rtl/ita_output_fifo_mem.sv | 27 ++
 rtl/ita_output_stage.sv | 92 +++++++++
 tb/tb_ita_output_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ita_output_stage_pkg.sv
// Shared types and sizing for the ITA output stage: beat layout, lane mask and tile geometry.
package ita_output_stage_pkg;

  localparam int unsigned N            = 16;
  localparam int unsigned WO           = 8;
  localparam int unsigned M            = 64;
  localparam int unsigned OupFifoDepth = 32;
  localparam int unsigned BeatsPerTile = M * M / N;

  typedef logic [N-1:0][WO-1:0] oup_beat_t;
  typedef logic [N-1:0]         requant_oup_t;

  // Padded lanes carry garbage from the datapath; force them to zero.
  function automatic oup_beat_t mask_beat(oup_beat_t beat, requant_oup_t mask);
    oup_beat_t res;
    for (int i = 0; i < N; i++) begin
      res[i] = mask[i] ? beat[i] : '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/ita_output_fifo_mem.sv
// Flop-based beat storage for the output FIFO: one write port, asynchronous read.
module ita_output_fifo_mem
  import ita_output_stage_pkg::*;
#(
  parameter  int unsigned DEPTH = OupFifoDepth,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  oup_beat_t     wdata,
  input  logic [PW-1:0] raddr,
  output oup_beat_t     rdata
);

  oup_beat_t mem_q [DEPTH];

  // Storage is never reset; the top gates the read data with the valid flag.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ita_output_stage.sv
// Output stage: masks final result beats, buffers them in a FIFO and streams them out per MxM tile.
module ita_output_stage
  import ita_output_stage_pkg::*;
#(
  parameter  int unsigned DEPTH = OupFifoDepth,
  parameter  int unsigned BPT   = BeatsPerTile,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned FW    = $clog2(DEPTH + 1),
  localparam int unsigned CW    = (BPT > 1) ? $clog2(BPT) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*WO-1:0] in_data_i,
  input  requant_oup_t    in_mask_i,
  input  logic            in_last_i,
  output logic            oup_valid_o,
  input  logic            oup_ready_i,
  output logic [N*WO-1:0] oup_data_o,
  output logic            oup_last_o,
  output logic            tile_done_o,
  output logic [FW-1:0]   fill_o
);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW-1:0] fill_q;
  logic [CW-1:0] cnt_q;
  logic          tile_done_q;
  logic          full, push, pop;
  oup_beat_t     wr_beat, head_beat;

  assign full        = (fill_q == FW'(DEPTH));
  assign in_ready_o  = rst_ni & ~full;
  assign oup_valid_o = (fill_q != '0);
  assign oup_last_o  = oup_valid_o & (cnt_q == CW'(BPT - 1));
  assign oup_data_o  = oup_valid_o ? head_beat : '0;
  assign tile_done_o = tile_done_q;
  assign fill_o      = fill_q;

  // Partial-sum beats are accepted but never stored; clear discards any handshake.
  assign push    = in_valid_i & in_ready_o & in_last_i & ~clear_i;
  assign pop     = oup_valid_o & oup_ready_i & ~clear_i;
  assign wr_beat = mask_beat(oup_beat_t'(in_data_i), in_mask_i);

  ita_output_fifo_mem #(.DEPTH(DEPTH)) i_mem (
    .clk_i (clk_i),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_beat),
    .raddr (rd_ptr_q),
    .rdata (head_beat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Beat position within the current output tile advances only on handshaked output beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      tile_done_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q       <= '0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= pop & oup_last_o;
      if (pop) begin
        cnt_q <= oup_last_o ? '0 : cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ita_output_stage.sv
// Randomized scoreboard bench for ita_output_stage against a queue-based reference model.
module tb_ita_output_stage;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned BPT   = 256;

  logic         clk;
  logic         rst_ni;
  logic         clear_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] in_data_i;
  logic [15:0]  in_mask_i;
  logic         in_last_i;
  logic         oup_valid_o;
  logic         oup_ready_i;
  logic [127:0] oup_data_o;
  logic         oup_last_o;
  logic         tile_done_o;
  logic [5:0]   fill_o;

  int compared   = 0;
  int mismatched = 0;

  logic [127:0] beatQ[$];
  int           poppedInTile = 0;
  logic         pendDone     = 1'b0;

  ita_output_stage #(.DEPTH(DEPTH), .BPT(BPT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_mask_i   (in_mask_i),
    .in_last_i   (in_last_i),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_data_o  (oup_data_o),
    .oup_last_o  (oup_last_o),
    .tile_done_o (tile_done_o),
    .fill_o      (fill_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] refMask(input logic [127:0] d, input logic [15:0] m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    end
    return r;
  endfunction

  // Monitor: samples mid-cycle, compares against the model, then advances the model for the next edge.
  always @(negedge clk) begin
    if (!rst_ni) begin
      checkOutput("rst_fill", 128'(fill_o), 128'd0);
      checkOutput("rst_valid", 128'(oup_valid_o), 128'd0);
      checkOutput("rst_ready", 128'(in_ready_o), 128'd0);
      checkOutput("rst_tile_done", 128'(tile_done_o), 128'd0);
      checkOutput("rst_data", oup_data_o, 128'd0);
      beatQ.delete();
      poppedInTile = 0;
      pendDone     = 1'b0;
    end else begin
      int  sz;
      bit  doPop, doPush, expLast;
      sz      = beatQ.size();
      expLast = (sz > 0) && (poppedInTile == BPT - 1);
      checkOutput("tile_done", 128'(tile_done_o), 128'(pendDone));
      checkOutput("fill", 128'(fill_o), 128'(sz));
      checkOutput("in_ready", 128'(in_ready_o), 128'(sz < DEPTH));
      checkOutput("oup_valid", 128'(oup_valid_o), 128'(sz > 0));
      checkOutput("oup_last", 128'(oup_last_o), 128'(expLast));
      if (sz > 0) checkOutput("oup_data", oup_data_o, beatQ[0]);
      doPop    = (sz > 0) && oup_ready_i && !clear_i;
      doPush   = in_valid_i && (sz < DEPTH) && in_last_i && !clear_i;
      pendDone = doPop && expLast;
      if (clear_i) begin
        beatQ.delete();
        poppedInTile = 0;
      end else begin
        if (doPop) begin
          void'(beatQ.pop_front());
          poppedInTile = (poppedInTile + 1) % BPT;
        end
        if (doPush) beatQ.push_back(refMask(in_data_i, in_mask_i));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [127:0] d, input logic [15:0] m,
                               input logic l, input logic r, input logic c);
    @(posedge clk);
    #1;
    in_valid_i  = v;
    in_data_i   = d;
    in_mask_i   = m;
    in_last_i   = l;
    oup_ready_i = r;
    clear_i     = c;
  endtask

  function automatic logic [127:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic randomTraffic(input int n, input bit readyRand);
    for (int i = 0; i < n; i++)
      applyStimulus(($urandom % 4) != 0, rndData(), 16'($urandom), ($urandom % 8) != 0,
                    readyRand ? 1'($urandom % 2) : 1'b0, 1'b0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_mask_i   = '0;
    in_last_i   = 1'b0;
    oup_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Lane masking on a single final beat.
    applyStimulus(1'b1, {16{8'hAA}}, 16'h00FF, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Partial-sum beats are consumed without being stored.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, rndData(), 16'($urandom), 1'b0, 1'b1, 1'b0);
    idle(2);

    // Fill to capacity under backpressure, then drain while still offering beats.
    for (int i = 0; i < 36; i++) applyStimulus(1'b1, rndData(), 16'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, rndData(), 16'($urandom), 1'b1, 1'b1, 1'b0);
    idle(40);

    // Two full tiles back-to-back, then random consumer stalls.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2 * BPT + 8; i++)
      applyStimulus(1'b1, rndData(), 16'($urandom), 1'b1, 1'b1, 1'b0);
    randomTraffic(1200, 1'b1);
    idle(40);

    // Push and pop together at fill 5, then clear against a valid push.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, rndData(), 16'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, rndData(), 16'($urandom), 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, rndData(), 16'($urandom), 1'b1, 1'b1, 1'b1);
    idle(3);

    // Asynchronous reset in the middle of traffic.
    randomTraffic(20, 1'b0);
    @(posedge clk);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("rst_async_valid", 128'(oup_valid_o), 128'd0);
    checkOutput("rst_async_fill", 128'(fill_o), 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    randomTraffic(200, 1'b1);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
